// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and read-mode constants for sync_fifo.
package sync_fifo_pkg;

  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a completely full FIFO (count == DEPTH) is representable.
  function automatic int count_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered flags, thresholds, occupancy and overflow/underflow pulses.
// Read side is either a registered one-cycle read or first-word-fall-through.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_TH      = DEPTH - 2,
  parameter int AE_TH      = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_wr_en,
  input  logic [DATA_WIDTH-1:0]           i_wr_data,
  input  logic                            i_rd_en,
  output logic [DATA_WIDTH-1:0]           o_rd_data,
  output logic                            o_rd_valid,
  output logic                            o_full,
  output logic                            o_almost_full,
  output logic                            o_empty,
  output logic                            o_almost_empty,
  output logic [count_width(DEPTH)-1:0]   o_count,
  output logic                            o_overflow,
  output logic                            o_underflow
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance looks only at the registered flags, never at same-cycle activity.
  assign wr_ok = i_wr_en && !o_full;
  assign rd_ok = i_rd_en && !o_empty;

  always_comb begin
    count_nxt = o_count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = o_count + CW'(1);
      2'b01:   count_nxt = o_count - CW'(1);
      default: count_nxt = o_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_empty        <= 1'b1;
      o_almost_empty <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      o_count        <= count_nxt;
      o_empty        <= (count_nxt == '0);
      o_almost_empty <= (count_nxt <= AE_C);
      o_full         <= (count_nxt == DEPTH_C);
      o_almost_full  <= (count_nxt >= AF_C);
      o_overflow     <= i_wr_en && o_full;
      o_underflow    <= i_rd_en && o_empty;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk    (i_clk),
    .wr_en  (wr_ok),
    .wr_addr(wr_ptr),
    .wr_data(i_wr_data),
    .rd_addr(rd_ptr),
    .rd_data(ram_rd_data)
  );

  generate
    if (FWFT == FWFT_STD) begin : g_std
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          o_rd_data  <= '0;
          o_rd_valid <= 1'b0;
        end else begin
          o_rd_valid <= rd_ok;
          if (rd_ok) o_rd_data <= ram_rd_data;
        end
      end
    end else begin : g_fwft
      // Head word is presented combinationally from the array while non-empty.
      assign o_rd_data  = ram_rd_data;
      assign o_rd_valid = !o_empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a standard-read instance and an FWFT instance, directed vectors.
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Standard-mode instance
  logic       s_rst, s_wr_en, s_rd_en;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_rd_valid, s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;

  // FWFT instance
  logic       f_rst, f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_rd_valid, f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AF_TH(14), .AE_TH(2)) u_std (
    .i_clk(clk), .i_rst(s_rst), .i_wr_en(s_wr_en), .i_wr_data(s_wr_data), .i_rd_en(s_rd_en),
    .o_rd_data(s_rd_data), .o_rd_valid(s_rd_valid), .o_full(s_full), .o_almost_full(s_af),
    .o_empty(s_empty), .o_almost_empty(s_ae), .o_count(s_count),
    .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1), .AF_TH(14), .AE_TH(2)) u_fwft (
    .i_clk(clk), .i_rst(f_rst), .i_wr_en(f_wr_en), .i_wr_data(f_wr_data), .i_rd_en(f_rd_en),
    .o_rd_data(f_rd_data), .o_rd_valid(f_rd_valid), .o_full(f_full), .o_almost_full(f_af),
    .o_empty(f_empty), .o_almost_empty(f_ae), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  logic [7:0] mq[$];     // reference contents of the standard FIFO
  logic [7:0] exp_q[$];  // words the monitor expects on o_rd_data, in order

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid standard-mode read must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!s_rst && s_rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got 0x%0h expected no valid word", s_rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (s_rd_data !== e) begin
          failures++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", s_rd_data, e, $time);
        end
      end
    end
  end

  // One standard-mode cycle: drive at negedge, outputs settle by the next negedge.
  task automatic s_step(input logic wr, input logic [7:0] wd, input logic rd);
    logic rd_acc, wr_acc;
    rd_acc = rd && (mq.size() > 0);
    wr_acc = wr && (mq.size() < 16);
    if (rd_acc) exp_q.push_back(mq.pop_front());
    if (wr_acc) mq.push_back(wd);
    s_wr_en = wr; s_wr_data = wd; s_rd_en = rd;
    @(posedge clk);
    @(negedge clk);
    s_wr_en = 1'b0; s_rd_en = 1'b0;
  endtask

  task automatic f_step(input logic wr, input logic [7:0] wd, input logic rd);
    f_wr_en = wr; f_wr_data = wd; f_rd_en = rd;
    @(posedge clk);
    @(negedge clk);
    f_wr_en = 1'b0; f_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst = 1'b1; s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_rst = 1'b0; f_rst = 1'b0;

    // Reset / idle state
    s_step(1'b0, 8'h00, 1'b0);
    chk("rst_empty", s_empty, 1);
    chk("rst_ae", s_ae, 1);
    chk("rst_count", s_count, 0);
    chk("rst_rd_valid", s_rd_valid, 0);
    chk("rst_rd_data", s_rd_data, 0);
    chk("rst_full", s_full, 0);
    chk("rst_af", s_af, 0);

    // Fill 0x00..0x0F, checking count and thresholds each step
    for (int i = 0; i < 16; i++) begin
      s_step(1'b1, 8'(i), 1'b0);
      chk("fill_count", s_count, i + 1);
      chk("fill_af", s_af, (i + 1 >= 14) ? 1 : 0);
      chk("fill_ae", s_ae, (i + 1 <= 2) ? 1 : 0);
      chk("fill_full", s_full, (i == 15) ? 1 : 0);
      chk("fill_ovf", s_ovf, 0);
    end
    s_step(1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", s_ovf, 1);
    chk("ovf_count", s_count, 16);
    s_step(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", s_ovf, 0);

    // Drain: monitor expects 0x00..0x0F
    for (int i = 0; i < 16; i++) s_step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", s_empty, 1);
    chk("drain_count", s_count, 0);
    s_step(1'b0, 8'h00, 1'b0);
    chk("drain_valid_low", s_rd_valid, 0);

    // Read at empty with a simultaneous write
    s_step(1'b1, 8'h55, 1'b1);
    chk("unf_pulse", s_unf, 1);
    chk("unf_count", s_count, 1);
    chk("unf_valid", s_rd_valid, 0);
    s_step(1'b0, 8'h00, 1'b1);
    chk("unf_clear", s_unf, 0);
    chk("read55_count", s_count, 0);

    // Full with rd+wr: read wins, write rejected
    for (int i = 0; i < 16; i++) s_step(1'b1, 8'(8'h80 + i), 1'b0);
    chk("full2", s_full, 1);
    s_step(1'b1, 8'h77, 1'b1);
    chk("rdwr_full_ovf", s_ovf, 1);
    chk("rdwr_full_count", s_count, 15);
    chk("rdwr_full_flag", s_full, 0);
    for (int i = 0; i < 7; i++) s_step(1'b0, 8'h00, 1'b1);
    chk("mid_count", s_count, 8);

    // Sustained rd+wr at count 8; pointers wrap repeatedly
    for (int i = 0; i < 40; i++) begin
      s_step(1'b1, 8'(8'hC0 + i), 1'b1);
      chk("stream_count", s_count, 8);
      chk("stream_flags", {s_empty, s_full, s_ovf, s_unf}, 0);
    end
    for (int i = 0; i < 8; i++) s_step(1'b0, 8'h00, 1'b1);
    s_step(1'b0, 8'h00, 1'b0);
    chk("final_empty", s_empty, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    // FWFT instance
    f_step(1'b1, 8'h3C, 1'b0);
    chk("fwft_data", f_rd_data, 8'h3C);
    chk("fwft_valid", f_rd_valid, 1);
    chk("fwft_not_empty", f_empty, 0);
    f_step(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", f_empty, 1);
    chk("fwft_pop_valid", f_rd_valid, 0);
    for (int i = 1; i <= 5; i++) f_step(1'b1, 8'(i), 1'b0);
    chk("fwft_count5", f_count, 5);
    chk("fwft_head", f_rd_data, 8'h01);
    f_rst = 1'b1;
    f_step(1'b1, 8'hEE, 1'b0);
    f_rst = 1'b0;
    chk("fwft_rst_count", f_count, 0);
    chk("fwft_rst_empty", f_empty, 1);
    chk("fwft_rst_valid", f_rd_valid, 0);
    f_step(1'b0, 8'h00, 1'b0);
    chk("fwft_rst_stays", f_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO with registered status flags, programmable almost-full/almost-empty thresholds, occupancy count and overflow/underflow reporting. It is the single-clock-domain buffer for the FPGA SoC datapaths, such as streaming between peripherals and bus masters. Read side is configurable between standard mode (registered read, one-cycle latency) and first-word-fall-through (FWFT) mode.

## Interface
- DATA_WIDTH, 8, bits per word (≥1)
- DEPTH, 16, number of words; power of two, ≥4
- FWFT, 0, 0 = standard read, 1 = first-word-fall-through
- AF_TH, DEPTH-2, o_almost_full asserted when count ≥ AF_TH (1..DEPTH)
- AE_TH, 2, o_almost_empty asserted when count ≤ AE_TH (0..DEPTH-1)

Ports (AW = $clog2(DEPTH)):
- i_clk  in  1  sole clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_wr_en  in  1  write request
- i_wr_data  in  DATA_WIDTH  write word
- i_rd_en  in  1  read request (pop in FWFT mode)
- o_rd_data  out  DATA_WIDTH  read word
- o_rd_valid  out  1  o_rd_data holds a valid popped/head word
- o_full  out  1  count == DEPTH
- o_almost_full  out  1  count ≥ AF_TH
- o_empty  out  1  count == 0
- o_almost_empty  out  1  count ≤ AE_TH
- o_count  out  AW+1  occupancy, 0..DEPTH
- o_overflow  out  1  one-cycle pulse: write rejected
- o_underflow  out  1  one-cycle pulse: read rejected

## Operation
- Write accepted iff i_wr_en && !o_full; word stored at wr_ptr, wr_ptr += 1 (wraps at DEPTH, natural AW-bit wrap).
- Read accepted iff i_rd_en && !o_empty; rd_ptr += 1 (wraps likewise).
- Rejected write: no state change, o_overflow = 1 next cycle. Rejected read: no state change, o_underflow = 1 next cycle.
- Acceptance is judged on registered flags only. Write at full is rejected even with a simultaneous accepted read. Read at empty is rejected even with a simultaneous accepted write.
- Count update: +1 (write only), −1 (read only), unchanged (both or neither accepted).
- All flags are registered and recomputed from the next count on the same edge as o_count.
- Standard mode: on accepted read, o_rd_data <= mem[rd_ptr] and o_rd_valid <= 1. Otherwise o_rd_valid <= 0 and o_rd_data holds its value.
- FWFT mode: o_rd_data = mem[rd_ptr] whenever !o_empty, and o_rd_valid = !o_empty. i_rd_en consumes the head word. o_rd_data is don't-care when empty.
- Storage array is not reset; contents are unobservable until written.

## Timing
- Reset, sync on edge with i_rst = 1: pointers = 0, count = 0, o_empty = 1, o_almost_empty = 1, o_full = 0, o_almost_full = 0 (AF_TH ≥ 1), o_rd_valid = 0, o_rd_data = 0, o_overflow = 0, o_underflow = 0.
- i_wr_en/i_rd_en are ignored during reset cycles. Reset mid-operation discards all queued words; the FIFO is empty on the next cycle.
- Write-to-status latency: 1 cycle (write at edge N → o_empty low after edge N).
- Standard read latency: 1 cycle (i_rd_en at edge N → data/valid after edge N).
- FWFT: a word written at edge N appears on o_rd_data after edge N.
- Full throughput: one write and one read per cycle sustained when 0 < count < DEPTH.
- Pointer wrap at DEPTH−1 → 0 must not disturb count or flags.

## Structure
- Shared package sync_fifo_pkg: AW derivation function/localparam, count width (AW+1), FWFT mode constants.
- One sub-module, sync_fifo_ram: DEPTH×DATA_WIDTH array with synchronous write port and asynchronous read port. No reset.
- The top level holds the pointers, count, flags, pulse registers and the mode-specific read register (generate on FWFT).

## Test plan
- Reset then idle (DEPTH=16): o_empty = 1, o_almost_empty = 1, o_count = 0, o_rd_valid = 0, o_rd_data = 0.
- Write 16 words 0x00..0x0F, then a 17th (0xAA): o_full = 1 after the 16th write, o_almost_full = 1 from count 14, o_overflow pulses once, o_count = 16. Drain: words read back as 0x00..0x0F in order, never 0xAA.
- Read on empty with simultaneous write 0x55: o_underflow pulses, o_count = 1. Next read returns 0x55.
- At full, assert rd+wr together (wr 0x77): read accepted, write rejected, o_overflow = 1, o_count = 15.
- Count 8, rd+wr every cycle for 40 cycles (pointers wrap twice): o_count stays 8 and data order is preserved.
- FWFT=1: write 0x3C at edge N → o_rd_data = 0x3C, o_rd_valid = 1 after N. Pop → o_empty = 1 next cycle. Assert i_rst mid-stream with count 5 → o_count = 0 next cycle.
